// File: rtl/regression_feature_gen_pkg.sv
// Shared types and sizing constants for the regression feature stage.
package regfeat_pkg;
  localparam int FEAT_W = 16;
  localparam int ACC_W  = 32;
  localparam int STEPS  = 16;
  localparam int CNT_W  = $clog2(STEPS);

  typedef enum logic [1:0] {IDLE, SQ, CUBE, DONE} state_t;
endpackage

// File: rtl/regression_feature_gen_seq_mult16.sv
// Iterative 16x16 shift-add multiplier, one multiplier bit per enabled cycle.
// The product port already includes the current step, so it is final while last is high.
module seq_mult16
  import regfeat_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              step_en,
  input  logic [FEAT_W-1:0] a,
  input  logic [FEAT_W-1:0] b,
  output logic [ACC_W-1:0]  product,
  output logic              last
);
  logic [ACC_W-1:0] acc_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [ACC_W-1:0] pp [STEPS];

  genvar gi;
  generate
    for (gi = 0; gi < STEPS; gi++) begin : g_pp
      assign pp[gi] = b[gi] ? ({{(ACC_W-FEAT_W){1'b0}}, a} << gi) : '0;
    end
  endgenerate

  assign product = acc_reg + pp[cnt_reg];
  assign last    = (cnt_reg == CNT_W'(STEPS-1));

  // Self-clears after the last step so the next pass starts from zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_reg <= '0;
      cnt_reg <= '0;
    end else if (start) begin
      acc_reg <= '0;
      cnt_reg <= '0;
    end else if (step_en) begin
      if (last) begin
        acc_reg <= '0;
        cnt_reg <= '0;
      end else begin
        acc_reg <= product;
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end
endmodule

// File: rtl/regression_feature_gen.sv
// Feature generator: f0 = x, f1 = x^2, f2 = f1*x in fixed point with one shared multiplier.
// Define FEAT_SAT_EN to saturate f1/f2 at 0xFFFF instead of wrapping.
module regression_feature_gen
  import regfeat_pkg::*;
#(
  parameter int FRAC = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [FEAT_W-1:0] x,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [FEAT_W-1:0] f0,
  output logic [FEAT_W-1:0] f1,
  output logic [FEAT_W-1:0] f2,
  output logic              busy
);
  state_t            state_reg, state_next;
  logic [FEAT_W-1:0] f0_reg, f1_reg, f2_reg;
  logic              mult_start, step_en, last;
  logic [FEAT_W-1:0] mult_a;
  logic [ACC_W-1:0]  product;
  logic [FEAT_W-1:0] narrowed;

  // The cube pass multiplies the already-narrowed f1 by x.
  assign mult_a = (state_reg == CUBE) ? f1_reg : f0_reg;

  seq_mult16 u_mult (
    .clk     (clk),
    .rst     (rst),
    .start   (mult_start),
    .step_en (step_en),
    .a       (mult_a),
    .b       (f0_reg),
    .product (product),
    .last    (last)
  );

`ifdef FEAT_SAT_EN
  logic [ACC_W-1:0] scaled;
  assign scaled   = product >> FRAC;
  assign narrowed = (|scaled[ACC_W-1:FEAT_W]) ? '1 : scaled[FEAT_W-1:0];
`else
  assign narrowed = FEAT_W'(product >> FRAC);
`endif

  always_comb begin
    state_next = state_reg;
    mult_start = 1'b0;
    step_en    = 1'b0;
    case (state_reg)
      IDLE: if (in_valid) begin
        state_next = SQ;
        mult_start = 1'b1;
      end
      SQ: begin
        step_en = 1'b1;
        if (last) state_next = CUBE;
      end
      CUBE: begin
        step_en = 1'b1;
        if (last) state_next = DONE;
      end
      DONE: if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      f0_reg    <= '0;
      f1_reg    <= '0;
      f2_reg    <= '0;
    end else begin
      state_reg <= state_next;
      if (mult_start)                  f0_reg <= x;
      if (state_reg == SQ && last)     f1_reg <= narrowed;
      if (state_reg == CUBE && last)   f2_reg <= narrowed;
    end
  end

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign busy      = (state_reg == SQ) || (state_reg == CUBE);
  assign f0 = f0_reg;
  assign f1 = f1_reg;
  assign f2 = f2_reg;
endmodule
